alu_checker: RTL and testbench
==============================

# alu_checker

Hardware self-checking monitor on the observing end of the ALU stimulus interface. Each enabled cycle it samples the operands `a`, `b`, the operation `sel` and the ALU result `out`, computes the expected result independently, and compares the two. It counts checks and mismatches, keeps a sticky error flag, and captures the first failing vector. It sits beside the `alu` instance in benches and on-board test harnesses, so a pass/fail verdict needs no waveform inspection.

## Interface
- `WIDTH`, 32: operand and result width.
- `CNT_W`, 16: width of the check and error counters.
- `MAX_ERR`, 0: the checker halts after this many mismatches. 0 means it never halts.

- `clk`  in  1: single clock. All state changes on the rising edge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `en`  in  1: sample the inputs on this edge.
- `clear`  in  1: synchronous clear of all results. Does not reset the configuration.
- `a`, `b`  in  WIDTH: operands driven to the ALU.
- `sel`  in  2: operation. 0 = add, 1 = subtract (a−b), 2 = AND, 3 = OR.
- `out`  in  WIDTH: ALU result under check.
- `check_count`  out  CNT_W: number of vectors compared.
- `err_count`  out  CNT_W: number of mismatches.
- `err`  out  1: sticky. Set on the first mismatch.
- `halted`  out  1: high while in the HALTED state.
- `first_err_valid`  out  1: the first-failure registers below hold data.
- `first_err_a`, `first_err_b`  out  WIDTH: operands of the first failing vector.
- `first_err_sel`  out  2: operation of the first failing vector.
- `first_err_out`  out  WIDTH: ALU result of the first failing vector.
- `first_err_exp`  out  WIDTH: expected result of the first failing vector.

## Operation
- **Stage 1 (capture):** on an edge with `en`=1 in the RUN state, register `a`, `b`, `sel`, `out` and set `v1`=1. Otherwise `v1`=0.
- **Stage 2 (compare):** on an edge with `v1`=1:
  - Compute the expected result from the stage-1 registers.
  - Increment `check_count`.
  - If the expected result differs from the captured `out`, increment `err_count` and set `err`=1.
  - If `first_err_valid`=0 on a mismatch, load all `first_err_*` registers and set `first_err_valid`=1. Later mismatches never overwrite them.
- **Arithmetic:** all operations are modulo 2^WIDTH. Carry and borrow are discarded, so 0xFFFFFFFF+1 = 0 and 0−1 = 0xFFFFFFFF.
- **Counters:** both saturate at 2^CNT_W−1 and never wrap. `err` stays set even when `err_count` is saturated.
- **State machine:**
  - RUN → HALTED on the edge where `err_count` becomes MAX_ERR, when MAX_ERR≠0.
  - On that same edge, the stage-1 capture is suppressed (`v1`←0).
  - In HALTED, `en` is ignored and no compares occur.
  - HALTED → RUN only on `clear` or reset.
- **clear:**
  - Zeroes the counters, `err`, `first_err_*`, and `v1`.
  - Returns the state to RUN.
  - Takes priority over a capture or compare on the same edge. The in-flight vector is dropped, not counted.
- **Reset (`rst_n`=0 at an edge):** same effect as `clear`, at any point, including mid-pipeline.

## Timing
- **Reset values:** all outputs 0. State is RUN, `v1`=0.
- **Latency:** a vector presented with `en`=1 at edge N is captured at N and compared at N+1. `check_count`, `err_count`, `err`, `first_err_*` and `halted` reflect it after edge N+1.
- **Throughput:** one vector per cycle. Back-to-back `en` sustains full rate.
- **Input stability:** `out` must be stable when sampled; the checker adds no settle delay. The driver asserts `en` only once `out` has settled for the current `a`, `b`, `sel`.
- **Simultaneous events:**
  - A compare at edge N+1 and a new capture at edge N+1 both proceed.
  - The halting compare discards the capture on the same edge.
  - When `clear` and `en` are both asserted, the capture is dropped.

## Test plan
- **Reset:** hold `rst_n`=0 for 2 cycles, then release → every output is 0 and `halted`=0. Then pulse `en` with a=5, b=3, sel=0, out=8 → `check_count`=1, `err`=0, two edges after `en`.
- **Clean stream:** 10 back-to-back correct vectors covering all four `sel` values, e.g. a=0xF0, b=0x3C → out=0x12C, 0xB4, 0x30, 0xFC → `check_count`=10, `err_count`=0, `err`=0.
- **First-error capture:**
  - Send sel=1, a=5, b=3, out=3 → `err`=1, `err_count`=1, `first_err_exp`=2, `first_err_out`=3.
  - Then send sel=2, a=1, b=1, out=0 → `err_count`=2; the `first_err_*` registers are unchanged.
- **Wrap-around:** sel=0, a=0xFFFFFFFF, b=1, out=0, followed by sel=1, a=0, b=1, out=0xFFFFFFFF → both pass, `err_count`=0.
- **Halt and clear:**
  - With MAX_ERR=3, send 5 consecutive bad vectors → `err_count`=3, `check_count`=3, `halted`=1.
  - Further `en` pulses change nothing.
  - Pulse `clear` → all outputs 0 and `halted`=0; the next good vector gives `check_count`=1.
- **Saturation and reset mid-run:**
  - With CNT_W=4, send 20 good vectors → `check_count`=15.
  - Assert `rst_n`=0 one cycle after an `en` → the in-flight vector is not counted and every output is 0.

Source files
------------

// File: rtl/alu_checker.sv
// Self-checking monitor for the ALU: recomputes each enabled vector one cycle later,
// counts checks and mismatches, and latches the first failing vector.
module alu_checker #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned MAX_ERR = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clear,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] out,
  output logic [CNT_W-1:0] check_count,
  output logic [CNT_W-1:0] err_count,
  output logic             err,
  output logic             halted,
  output logic             first_err_valid,
  output logic [WIDTH-1:0] first_err_a,
  output logic [WIDTH-1:0] first_err_b,
  output logic [1:0]       first_err_sel,
  output logic [WIDTH-1:0] first_err_out,
  output logic [WIDTH-1:0] first_err_exp
);

  typedef enum logic {RUN, HALTED} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_nxt;
  logic             v1;
  logic [WIDTH-1:0] a1, b1, out1, exp_res;
  logic [1:0]       sel1;
  logic             mismatch, halt_now, capture;
  logic [CNT_W-1:0] check_count_inc, err_count_inc;

  always_comb begin
    exp_res = '0;
    case (sel1)
      2'd0: exp_res = a1 + b1;
      2'd1: exp_res = a1 - b1;
      2'd2: exp_res = a1 & b1;
      2'd3: exp_res = a1 | b1;
      default: exp_res = '0;
    endcase
  end

  always_comb begin
    mismatch        = v1 && (exp_res != out1);
    check_count_inc = (check_count == CNT_MAX) ? check_count : check_count + CNT_W'(1);
    err_count_inc   = (err_count == CNT_MAX) ? err_count : err_count + CNT_W'(1);
    // Halt only on the increment that lands on MAX_ERR; a saturated counter cannot re-trigger.
    halt_now        = (MAX_ERR != 0) && mismatch && (err_count != CNT_MAX) &&
                      (64'(err_count_inc) == 64'(MAX_ERR));
    capture         = en && (state == RUN) && !halt_now && !clear;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (halt_now) state_nxt = HALTED;
      HALTED:  state_nxt = HALTED;
      default: state_nxt = RUN;
    endcase
    if (clear) state_nxt = RUN;
  end

  always_comb begin
    halted = (state == HALTED);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      v1              <= 1'b0;
      a1              <= '0;
      b1              <= '0;
      sel1            <= '0;
      out1            <= '0;
      check_count     <= '0;
      err_count       <= '0;
      err             <= 1'b0;
      first_err_valid <= 1'b0;
      first_err_a     <= '0;
      first_err_b     <= '0;
      first_err_sel   <= '0;
      first_err_out   <= '0;
      first_err_exp   <= '0;
    end else begin
      v1 <= capture;
      if (capture) begin
        a1   <= a;
        b1   <= b;
        sel1 <= sel;
        out1 <= out;
      end
      if (v1) begin
        check_count <= check_count_inc;
        if (mismatch) begin
          err_count <= err_count_inc;
          err       <= 1'b1;
          if (!first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_a     <= a1;
            first_err_b     <= b1;
            first_err_sel   <= sel1;
            first_err_out   <= out1;
            first_err_exp   <= exp_res;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_checker.sv
// Directed bench for alu_checker: a vector table plus hand-written halt, clear,
// saturation and mid-pipeline reset sequences.
module tb_alu_checker;

  logic        clk = 1'b0;
  logic        rst_n, en, clear;
  logic [31:0] a, b, out;
  logic [1:0]  sel;

  logic [3:0]  check_count, err_count;
  logic        err, halted, first_err_valid;
  logic [31:0] first_err_a, first_err_b, first_err_out, first_err_exp;
  logic [1:0]  first_err_sel;

  logic [15:0] f_check_count, f_err_count;
  logic        f_err, f_halted, f_first_err_valid;
  logic [31:0] f_first_err_a, f_first_err_b, f_first_err_out, f_first_err_exp;
  logic [1:0]  f_first_err_sel;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_checker #(.WIDTH(32), .CNT_W(4), .MAX_ERR(3)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear),
    .a(a), .b(b), .sel(sel), .out(out),
    .check_count(check_count), .err_count(err_count), .err(err), .halted(halted),
    .first_err_valid(first_err_valid), .first_err_a(first_err_a), .first_err_b(first_err_b),
    .first_err_sel(first_err_sel), .first_err_out(first_err_out), .first_err_exp(first_err_exp)
  );

  alu_checker #(.WIDTH(32), .CNT_W(16), .MAX_ERR(0)) dut_free (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear),
    .a(a), .b(b), .sel(sel), .out(out),
    .check_count(f_check_count), .err_count(f_err_count), .err(f_err), .halted(f_halted),
    .first_err_valid(f_first_err_valid), .first_err_a(f_first_err_a), .first_err_b(f_first_err_b),
    .first_err_sel(f_first_err_sel), .first_err_out(f_first_err_out), .first_err_exp(f_first_err_exp)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  sel;
    logic [31:0] out;
    logic        bad;
  } vec_t;

  localparam int NV = 12;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] va, input logic [31:0] vb,
                       input logic [1:0] vs, input logic [31:0] vo);
    a = va; b = vb; sel = vs; out = vo; en = 1'b1;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; en = 1'b0;
    tick();
    clear = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_check_count"}, 64'(check_count), 64'd0);
    chk({tag, "_err_count"}, 64'(err_count), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
    chk({tag, "_halted"}, 64'(halted), 64'd0);
    chk({tag, "_fe_valid"}, 64'(first_err_valid), 64'd0);
    chk({tag, "_fe_a"}, 64'(first_err_a), 64'd0);
    chk({tag, "_fe_b"}, 64'(first_err_b), 64'd0);
    chk({tag, "_fe_sel"}, 64'(first_err_sel), 64'd0);
    chk({tag, "_fe_out"}, 64'(first_err_out), 64'd0);
    chk({tag, "_fe_exp"}, 64'(first_err_exp), 64'd0);
  endtask

  initial begin
    int nb;
    tbl[0]  = '{32'h0000_00F0, 32'h0000_003C, 2'd0, 32'h0000_012C, 1'b0};
    tbl[1]  = '{32'h0000_00F0, 32'h0000_003C, 2'd1, 32'h0000_00B4, 1'b0};
    tbl[2]  = '{32'h0000_00F0, 32'h0000_003C, 2'd2, 32'h0000_0030, 1'b0};
    tbl[3]  = '{32'h0000_00F0, 32'h0000_003C, 2'd3, 32'h0000_00FC, 1'b0};
    tbl[4]  = '{32'd5,         32'd3,         2'd0, 32'd8,         1'b0};
    tbl[5]  = '{32'hFFFF_FFFF, 32'd1,         2'd0, 32'h0000_0000, 1'b0};
    tbl[6]  = '{32'd0,         32'd1,         2'd1, 32'hFFFF_FFFF, 1'b0};
    tbl[7]  = '{32'h1234_5678, 32'h0F0F_0F0F, 2'd2, 32'h0204_0608, 1'b0};
    tbl[8]  = '{32'h1234_5678, 32'h0F0F_0F0F, 2'd3, 32'h1F3F_5F7F, 1'b0};
    tbl[9]  = '{32'd10,        32'd3,         2'd1, 32'd7,         1'b0};
    tbl[10] = '{32'd5,         32'd3,         2'd1, 32'd3,         1'b1};
    tbl[11] = '{32'd1,         32'd1,         2'd2, 32'd0,         1'b1};

    rst_n = 1'b0; en = 1'b0; clear = 1'b0;
    a = '0; b = '0; sel = '0; out = '0;

    // Reset and first-vector latency
    tick(); tick();
    rst_n = 1'b1;
    check_zero("reset");
    tick();
    check_zero("reset_idle");
    drive(32'd5, 32'd3, 2'd0, 32'd8);
    tick();
    en = 1'b0;
    chk("latency_n", 64'(check_count), 64'd0);
    tick();
    chk("latency_n1_count", 64'(check_count), 64'd1);
    chk("latency_n1_err", 64'(err), 64'd0);

    // Back-to-back table: clean stream then two mismatches
    pulse_clear();
    chk("clear_count", 64'(check_count), 64'd0);
    nb = 0;
    for (int i = 0; i <= NV; i++) begin
      if (i < NV) drive(tbl[i].a, tbl[i].b, tbl[i].sel, tbl[i].out);
      else en = 1'b0;
      tick();
      if (i > 0) begin
        if (tbl[i-1].bad) nb++;
        chk("tbl_check_count", 64'(check_count), 64'(i));
        chk("tbl_err_count", 64'(err_count), 64'(nb));
        chk("tbl_err", 64'(err), 64'(nb != 0));
      end
    end
    chk("fe_valid", 64'(first_err_valid), 64'd1);
    chk("fe_a", 64'(first_err_a), 64'd5);
    chk("fe_b", 64'(first_err_b), 64'd3);
    chk("fe_sel", 64'(first_err_sel), 64'd1);
    chk("fe_out", 64'(first_err_out), 64'd3);
    chk("fe_exp", 64'(first_err_exp), 64'd2);
    chk("two_err_not_halted", 64'(halted), 64'd0);

    // Halt after MAX_ERR mismatches; free-running instance keeps counting
    pulse_clear();
    for (int i = 0; i < 5; i++) begin
      drive(32'd1, 32'd1, 2'd0, 32'd0);
      tick();
    end
    en = 1'b0;
    tick();
    chk("halt_err_count", 64'(err_count), 64'd3);
    chk("halt_check_count", 64'(check_count), 64'd3);
    chk("halt_halted", 64'(halted), 64'd1);
    chk("free_err_count", 64'(f_err_count), 64'd5);
    chk("free_halted", 64'(f_halted), 64'd0);
    drive(32'd2, 32'd2, 2'd0, 32'd4);
    tick();
    en = 1'b0;
    tick();
    chk("halted_ignore_count", 64'(check_count), 64'd3);
    chk("halted_ignore_err", 64'(err_count), 64'd3);
    chk("halted_stays", 64'(halted), 64'd1);

    // clear together with en drops the capture
    drive(32'd2, 32'd2, 2'd0, 32'd4);
    clear = 1'b1;
    tick();
    clear = 1'b0; en = 1'b0;
    tick();
    check_zero("clear_en");
    drive(32'd7, 32'd2, 2'd1, 32'd5);
    tick();
    en = 1'b0;
    tick();
    chk("after_clear_count", 64'(check_count), 64'd1);
    chk("after_clear_halted", 64'(halted), 64'd0);

    // Counter saturation at 2^CNT_W-1
    pulse_clear();
    for (int i = 0; i < 20; i++) begin
      drive(32'(i), 32'(2 * i), 2'd0, 32'(3 * i));
      tick();
    end
    en = 1'b0;
    tick();
    chk("sat_check_count", 64'(check_count), 64'd15);
    chk("sat_err_count", 64'(err_count), 64'd0);
    chk("sat_free_count", 64'(f_check_count), 64'd20);

    // Reset one cycle after en: in-flight vector lost, all outputs cleared
    pulse_clear();
    drive(32'd2, 32'd2, 2'd0, 32'd5);
    tick();
    en = 1'b0;
    tick();
    chk("pre_rst_err", 64'(err), 64'd1);
    chk("pre_rst_fe_exp", 64'(first_err_exp), 64'd4);
    drive(32'd3, 32'd4, 2'd3, 32'd7);
    tick();
    en = 1'b0;
    rst_n = 1'b0;
    tick();
    check_zero("mid_rst");
    rst_n = 1'b1;
    tick();
    check_zero("post_rst");
    chk("post_rst_free_count", 64'(f_check_count), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
